// File: rtl/rope_launcher.sv
// rope_launcher: fire controller feeding the rope trajectory stage.
// Detects fire-key edges, latches the clamped rope column at launch, tracks
// the shot through flight, counts ball hits and enforces a per-shot cooldown.
// Optional feature: define ROPE_FIRE_QUEUE_EN to remember one fire press made
// while a shot is in progress and launch it automatically on return to IDLE.
module rope_launcher #(
    parameter int unsigned X_OFFSET        = 16,
    parameter int unsigned X_MAX           = 639,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        gameEnable,
    input  logic        fireKey,
    input  logic [10:0] playerX,
    input  logic        movingUp,
    input  logic        col_rope_ball,
    output logic        deploy,
    output logic [10:0] ropeX,
    output logic        ropeActive,
    output logic        hitPulse,
    output logic [7:0]  hitCount
);

    typedef enum logic [1:0] {StIdle, StLaunch, StFlying, StCooldown} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_fire_key_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        r_first;
    logic        w_first_next;
    logic        w_hit;
    logic        w_launch;
    logic        w_fire_edge;
    logic        w_pending;
    logic [11:0] w_rope_sum;
    logic [10:0] w_rope_clamped;
    logic        r_deploy;
    logic [10:0] r_rope_x;
    logic        r_rope_active;
    logic        r_hit_pulse;
    logic [7:0]  r_hit_count;

    assign w_fire_edge    = fireKey & ~r_fire_key_d;
    // 12-bit sum so playerX near 2047 cannot wrap below X_MAX.
    assign w_rope_sum     = {1'b0, playerX} + 12'(X_OFFSET);
    assign w_rope_clamped = (w_rope_sum > 12'(X_MAX)) ? 11'(X_MAX) : w_rope_sum[10:0];

`ifdef ROPE_FIRE_QUEUE_EN
    logic r_pending;

    // Capture one fire edge made while a shot is busy; consumed in IDLE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pending <= 1'b0;
        end else if (!gameEnable || r_state == StIdle) begin
            r_pending <= 1'b0;
        end else if (w_fire_edge) begin
            r_pending <= 1'b1;
        end
    end

    assign w_pending = r_pending;
`else
    assign w_pending = 1'b0;
`endif

    // Next-state logic for the shot FSM, cooldown counter and flight guard.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_first_next = 1'b0;
        w_hit        = 1'b0;
        w_launch     = 1'b0;
        if (!gameEnable) begin
            w_state_next = StIdle;
            w_cnt_next   = 4'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_fire_edge || w_pending) begin
                        w_state_next = StLaunch;
                        w_launch     = 1'b1;
                    end
                end
                StLaunch: begin
                    if (startOfFrame) begin
                        w_state_next = StFlying;
                        w_first_next = 1'b1;
                    end
                end
                StFlying: begin
                    // Collision wins over climb-complete in the same cycle.
                    if (col_rope_ball) begin
                        w_state_next = StCooldown;
                        w_cnt_next   = 4'(COOLDOWN_FRAMES);
                        w_hit        = 1'b1;
                    end else if (!movingUp && !r_first) begin
                        w_state_next = StCooldown;
                        w_cnt_next   = 4'(COOLDOWN_FRAMES);
                    end
                end
                StCooldown: begin
                    if (r_cnt == 4'd0) begin
                        w_state_next = StIdle;
                    end else if (startOfFrame) begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // State, history and registered Moore outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= StIdle;
            r_fire_key_d  <= 1'b0;
            r_cnt         <= 4'd0;
            r_first       <= 1'b0;
            r_deploy      <= 1'b0;
            r_rope_x      <= 11'd0;
            r_rope_active <= 1'b0;
            r_hit_pulse   <= 1'b0;
            r_hit_count   <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_fire_key_d  <= fireKey;
            r_cnt         <= w_cnt_next;
            r_first       <= w_first_next;
            r_deploy      <= (w_state_next == StLaunch);
            r_rope_active <= (w_state_next == StLaunch) || (w_state_next == StFlying);
            r_hit_pulse   <= w_hit;
            if (w_launch) begin
                r_rope_x <= w_rope_clamped;
            end
            if (w_hit && r_hit_count != 8'hff) begin
                r_hit_count <= r_hit_count + 8'd1;
            end
        end
    end

    assign deploy     = r_deploy;
    assign ropeX      = r_rope_x;
    assign ropeActive = r_rope_active;
    assign hitPulse   = r_hit_pulse;
    assign hitCount   = r_hit_count;

endmodule

// File: tb/tb_rope_launcher.sv
// tb_rope_launcher: directed self-checking bench for rope_launcher
// (defaults X_OFFSET=16, X_MAX=639, COOLDOWN_FRAMES=4).
module tb_rope_launcher;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        gameEnable;
    logic        fireKey;
    logic [10:0] playerX;
    logic        movingUp;
    logic        col_rope_ball;
    logic        deploy;
    logic [10:0] ropeX;
    logic        ropeActive;
    logic        hitPulse;
    logic [7:0]  hitCount;

    int n_err = 0;
    int n_chk = 0;

    rope_launcher dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .gameEnable    (gameEnable),
        .fireKey       (fireKey),
        .playerX       (playerX),
        .movingUp      (movingUp),
        .col_rope_ball (col_rope_ball),
        .deploy        (deploy),
        .ropeX         (ropeX),
        .ropeActive    (ropeActive),
        .hitPulse      (hitPulse),
        .hitCount      (hitCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete shot ending on a hit, followed by the full cooldown.
    task automatic hit_shot();
        fireKey = 1'b1;
        tick();
        fireKey      = 1'b0;
        movingUp     = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        col_rope_ball = 1'b1;
        tick();
        col_rope_ball = 1'b0;
        repeat (4) frame();
        tick();
    endtask

    initial begin
        resetN        = 1'b0;
        startOfFrame  = 1'b0;
        gameEnable    = 1'b1;
        fireKey       = 1'b0;
        playerX       = 11'd0;
        movingUp      = 1'b0;
        col_rope_ball = 1'b0;
        tick();
        tick();
        chk("rst_deploy", deploy, 0);
        chk("rst_ropeX", ropeX, 0);
        chk("rst_active", ropeActive, 0);
        chk("rst_hitpulse", hitPulse, 0);
        chk("rst_hitcount", hitCount, 0);
        resetN = 1'b1;
        tick();

        // Reset then fire
        playerX = 11'd100;
        fireKey = 1'b1;
        tick();
        chk("fire_deploy", deploy, 1);
        chk("fire_ropeX", ropeX, 116);
        chk("fire_active", ropeActive, 1);
        fireKey = 1'b0;
        tick();
        chk("launch_wait_deploy", deploy, 1);
        startOfFrame = 1'b1;
        movingUp     = 1'b1;
        #1;
        chk("deploy_in_sof_cycle", deploy, 1);
        tick();
        startOfFrame = 1'b0;
        chk("deploy_fall", deploy, 0);
        chk("flying_active", ropeActive, 1);
        tick();
        // Hit path
        col_rope_ball = 1'b1;
        tick();
        col_rope_ball = 1'b0;
        chk("hit_pulse", hitPulse, 1);
        chk("hit_count1", hitCount, 1);
        chk("hit_inactive", ropeActive, 0);
        tick();
        chk("hit_pulse_one_cycle", hitPulse, 0);
        repeat (3) frame();
        fireKey = 1'b1;
        tick();
        chk("cooldown_ignore", deploy, 0);
        fireKey = 1'b0;
        tick();
        frame();
        tick();
        // Clamp
        playerX = 11'd630;
        fireKey = 1'b1;
        tick();
        chk("after_cooldown_fire", deploy, 1);
        chk("clamp_630", ropeX, 639);
        fireKey = 1'b0;

        // Climb complete, with first-cycle guard on movingUp
        startOfFrame = 1'b1;
        movingUp     = 1'b1;
        tick();
        startOfFrame = 1'b0;
        movingUp     = 1'b0;
        tick();
        chk("guard_first_cycle", ropeActive, 1);
        tick();
        chk("climb_inactive", ropeActive, 0);
        chk("climb_no_pulse", hitPulse, 0);
        chk("climb_count", hitCount, 1);
        repeat (4) frame();
        tick();

        // Simultaneous collision and climb complete, plus clamp at 2047
        playerX = 11'd2047;
        fireKey = 1'b1;
        tick();
        chk("clamp_2047", ropeX, 639);
        fireKey      = 1'b0;
        startOfFrame = 1'b1;
        movingUp     = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        movingUp      = 1'b0;
        col_rope_ball = 1'b1;
        tick();
        col_rope_ball = 1'b0;
        chk("simul_pulse", hitPulse, 1);
        chk("simul_count", hitCount, 2);
        repeat (4) frame();
        tick();

        // Held key through shot and cooldown
        playerX = 11'd200;
        fireKey = 1'b1;
        tick();
        chk("held_ropeX", ropeX, 216);
        startOfFrame = 1'b1;
        movingUp     = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        movingUp = 1'b0;
        tick();
        repeat (4) frame();
        tick();
        tick();
        tick();
        chk("held_no_relaunch", deploy, 0);
        chk("held_inactive", ropeActive, 0);
        fireKey = 1'b0;
        tick();

        // Abort in LAUNCH
        playerX = 11'd300;
        fireKey = 1'b1;
        tick();
        chk("abort_pre_deploy", deploy, 1);
        fireKey    = 1'b0;
        gameEnable = 1'b0;
        tick();
        chk("abort_deploy", deploy, 0);
        chk("abort_inactive", ropeActive, 0);
        chk("abort_ropeX_hold", ropeX, 316);
        gameEnable = 1'b1;
        tick();
        playerX = 11'd0;
        fireKey = 1'b1;
        tick();
        chk("abort_then_idle_fire", deploy, 1);
        chk("abort_then_ropeX", ropeX, 16);
        fireKey    = 1'b0;
        gameEnable = 1'b0;
        tick();
        gameEnable = 1'b1;
        chk("abort_keeps_count", hitCount, 2);
        tick();

        // Asynchronous reset mid-shot with key held
        playerX = 11'd50;
        fireKey = 1'b1;
        tick();
        resetN = 1'b0;
        #1;
        chk("async_rst_deploy", deploy, 0);
        chk("async_rst_ropeX", ropeX, 0);
        chk("async_rst_count", hitCount, 0);
        tick();
        resetN = 1'b1;
        tick();
        chk("post_rst_fire", deploy, 1);
        chk("post_rst_ropeX", ropeX, 66);
        gameEnable = 1'b0;
        tick();
        gameEnable = 1'b1;
        tick();
        tick();
        chk("post_rst_held_once", deploy, 0);
        fireKey = 1'b0;
        tick();

        // Hit count saturation
        playerX = 11'd10;
        repeat (255) hit_shot();
        chk("count_255", hitCount, 255);
        fireKey = 1'b1;
        tick();
        fireKey      = 1'b0;
        movingUp     = 1'b1;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        col_rope_ball = 1'b1;
        tick();
        col_rope_ball = 1'b0;
        chk("sat_pulse", hitPulse, 1);
        chk("sat_count", hitCount, 255);
        repeat (4) frame();
        tick();

        // Fire edge during FLYING
        playerX = 11'd400;
        fireKey = 1'b1;
        tick();
        chk("queue_first_ropeX", ropeX, 416);
        fireKey      = 1'b0;
        startOfFrame = 1'b1;
        movingUp     = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
        playerX = 11'd500;
        fireKey = 1'b1;
        tick();
        fireKey  = 1'b0;
        movingUp = 1'b0;
        tick();
        chk("queue_cooldown", ropeActive, 0);
        repeat (4) frame();
        tick();
        tick();
`ifdef ROPE_FIRE_QUEUE_EN
        chk("queue_relaunch", deploy, 1);
        chk("queue_ropeX", ropeX, 516);
`else
        chk("noqueue_no_relaunch", deploy, 0);
        chk("noqueue_ropeX", ropeX, 416);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
